fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control-side partner of the instruction fetch unit. It drives the fetch port's `en_pc` / `en_new_pc` / `new_pc`, consumes the 16-bit `instruction` it returns, and decodes it. Jumps and branches are resolved locally by redirecting fetch. All other instructions are forwarded to the execute stage over a valid/ready handshake, together with their address.

## Interface
- `PC_W`, default 12: program-counter width; must equal the fetch unit's PC width.
- `clk`  in  1: clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `en_pc`  out  1: fetch strobe. Fetch returns `mem[pc]` on the next edge, then `pc++`.
- `en_new_pc`  out  1: redirect strobe. Fetch returns `mem[new_pc]` on the next edge and sets `pc=new_pc` without increment. Has priority over `en_pc` at fetch.
- `new_pc`  out  PC_W: redirect target.
- `instruction`  in  16: fetch output; valid in the cycle after an `en_pc` edge.
- `zero_flag`  in  1: execute-stage zero flag, used by conditional branches.
- `exec_busy`  in  1: execute has an in-flight op that may still change `zero_flag`.
- `op_valid`  out  1: decoded op available.
- `op_ready`  in  1: execute accepts the op.
- `op_code`  out  4: `instruction[15:12]`.
- `op_rd`, `op_rs`, `op_rt`  out  4 each: `instruction[11:8]`, `[7:4]`, `[3:0]`.
- `op_pc`  out  PC_W: address of the forwarded instruction.
- `halted`  out  1: HALT executed; sticky until reset.

## Operation
- Opcodes:
  - 0x0 NOP: dropped, not forwarded.
  - 0x1–0x9: ALU ops, forwarded.
  - 0xA JMP: absolute jump to `instr[11:0]`.
  - 0xB JZ: taken when `zero_flag`=1.
  - 0xC JNZ: taken when `zero_flag`=0.
  - 0xF HALT.
  - 0xD, 0xE: reserved; treated as NOP.
- Internal `spc` (PC_W) shadows the fetch unit's PC.
  - Reset value is 0.
  - Incremented modulo 2^PC_W on every `en_pc`.
  - Loaded with the target on redirect. The first `en_pc` after a redirect returns the target instruction, and `spc` becomes target+1.
- `cur_pc` records the `spc` value at the time of each `en_pc`; it becomes `op_pc`.
- FSM states and transitions:
  - FETCH: `en_pc`=1 for one cycle; then go to DECODE.
  - DECODE: sample `instruction`.
    - NOP/reserved → FETCH.
    - ALU op → register fields and `op_pc` → ISSUE.
    - JMP → REDIRECT.
    - JZ/JNZ: if `exec_busy`=1, stay in DECODE (re-sample each cycle). Otherwise taken → REDIRECT; not taken → FETCH.
    - HALT → HALTED.
  - ISSUE: `op_valid`=1, fields held stable. When `op_valid && op_ready` → FETCH.
  - REDIRECT: `en_new_pc`=1 and `new_pc`=target for one cycle; `spc`←target; → FETCH. The instruction fetch returns on this edge is never decoded.
  - HALTED: no strobes; `halted`=1; remain here until reset.
- `en_pc` and `en_new_pc` are never high in the same cycle.
- Branch targets are absolute, truncated to PC_W bits.

## Timing
- Reset (async): state→FETCH, `spc`=0.
- Reset values of outputs: `en_pc`, `en_new_pc`, `new_pc`, `op_valid`, `op_code`, `op_rd`, `op_rs`, `op_rt`, `op_pc`, `halted` are all 0.
- First `en_pc` is in the first cycle after reset deassertion.
- Strobes are registered-state decodes. Each is high for exactly one cycle per FETCH or REDIRECT visit.
- ALU op latency: `en_pc` cycle N, decode cycle N+1, `op_valid` from cycle N+2. With `op_ready` held high, the next `en_pc` comes at N+3, giving 3 cycles per op.
- Backpressure: `op_valid` stays high and fields stay stable until the handshake. No new fetch is issued while in ISSUE.
- NOP / not-taken branch: 2 cycles.
- Taken jump/branch: 3 cycles; target `en_pc` follows `en_new_pc` in the next cycle.
- `exec_busy` stall: each busy cycle adds 1 cycle; `zero_flag` is sampled in the first cycle with `exec_busy`=0.
- `spc` wrap: fetch at 2^PC_W−1 is followed by fetch at 0; `op_pc` reports 0xFFF then 0x000.
- Reset mid-ISSUE or mid-REDIRECT: outputs clear immediately (async). The op is lost and sequencing restarts at address 0.

## Test plan
- Reset, memory {0:0x0000, 1:0x1123} → `en_pc` pulses at cycles 1, 3; `op_valid` at cycle 5 with `op_code`=1, `op_rd`=1, `op_rs`=2, `op_rt`=3, `op_pc`=1.
- ALU op at 0 with `op_ready` low for 4 cycles → `op_valid` high and fields stable for 5 cycles; no `en_pc` until the cycle after the handshake.
- 0:0xA100 (JMP 0x100), 0x100:0x2456 → `en_new_pc`=1 with `new_pc`=0x100, then `en_pc`; forwarded op has `op_pc`=0x100 and `op_code`=2.
- JZ 0x020 with `exec_busy`=1 for 3 cycles, then `zero_flag`=1 → stays in DECODE 3 extra cycles, then redirects to 0x020. Repeat with `zero_flag`=0 → sequential fetch of the next address, no `en_new_pc`.
- 0xFFF:0x3000 reached by JMP 0xFFF, 0x000:0xF000 → `op_pc`=0xFFF forwarded; then HALT from 0x000 → `halted`=1 and no strobes for 20 cycles.
- Assert `reset` while `op_valid`=1 → `op_valid`, `halted`, and strobes go to 0 immediately; after release the first `en_pc` fetches address 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-side sequencer: drives the fetch port, decodes returned words,
// resolves jumps/branches locally and forwards ALU ops to execute.
module fetch_sequencer #(
  parameter int PC_W = 12
) (
  input  logic            clk,
  input  logic            reset,
  output logic            en_pc,
  output logic            en_new_pc,
  output logic [PC_W-1:0] new_pc,
  input  logic [15:0]     instruction,
  input  logic            zero_flag,
  input  logic            exec_busy,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [3:0]      op_code,
  output logic [3:0]      op_rd,
  output logic [3:0]      op_rs,
  output logic [3:0]      op_rt,
  output logic [PC_W-1:0] op_pc,
  output logic            halted
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    ISSUE,
    REDIRECT,
    HALTED
  } state_t;

  state_t          state;
  logic [PC_W-1:0] spc;
  logic [PC_W-1:0] cur_pc;
  logic [PC_W-1:0] target;
  logic [3:0]      opc;
  logic            is_alu;
  logic            is_jmp;
  logic            is_br;
  logic            is_hlt;
  logic            taken;

  assign opc    = instruction[15:12];
  assign target = PC_W'(instruction[11:0]);
  assign is_alu = (opc >= 4'h1) && (opc <= 4'h9);
  assign is_jmp = (opc == 4'hA);
  assign is_br  = (opc == 4'hB) || (opc == 4'hC);
  assign is_hlt = (opc == 4'hF);
  assign taken  = (opc == 4'hB) ? zero_flag : ~zero_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      spc       <= '0;
      cur_pc    <= '0;
      en_pc     <= 1'b0;
      en_new_pc <= 1'b0;
      new_pc    <= '0;
      op_valid  <= 1'b0;
      op_code   <= '0;
      op_rd     <= '0;
      op_rs     <= '0;
      op_rt     <= '0;
      op_pc     <= '0;
      halted    <= 1'b0;
    end else begin
      en_pc     <= 1'b0;
      en_new_pc <= 1'b0;
      unique case (state)
        FETCH: begin
          // en_pc low here only right after reset: raise it first
          if (en_pc) begin
            state  <= DECODE;
            cur_pc <= spc;
            spc    <= spc + PC_W'(1);
          end else begin
            en_pc <= 1'b1;
          end
        end
        DECODE: begin
          unique case (1'b1)
            is_alu: begin
              state    <= ISSUE;
              op_valid <= 1'b1;
              op_code  <= opc;
              op_rd    <= instruction[11:8];
              op_rs    <= instruction[7:4];
              op_rt    <= instruction[3:0];
              op_pc    <= cur_pc;
            end
            is_jmp: begin
              state     <= REDIRECT;
              en_new_pc <= 1'b1;
              new_pc    <= target;
            end
            is_br: begin
              if (!exec_busy) begin
                if (taken) begin
                  state     <= REDIRECT;
                  en_new_pc <= 1'b1;
                  new_pc    <= target;
                end else begin
                  state <= FETCH;
                  en_pc <= 1'b1;
                end
              end
            end
            is_hlt: begin
              state  <= HALTED;
              halted <= 1'b1;
            end
            default: begin
              state <= FETCH;
              en_pc <= 1'b1;
            end
          endcase
        end
        ISSUE: begin
          if (op_ready) begin
            state    <= FETCH;
            op_valid <= 1'b0;
            en_pc    <= 1'b1;
          end
        end
        REDIRECT: begin
          state <= FETCH;
          spc   <= new_pc;
          en_pc <= 1'b1;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural fetch unit, directed programs,
// queue scoreboard with an independent handshake monitor.
module tb_fetch_sequencer;

  localparam int PC_W = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en_pc;
  logic            en_new_pc;
  logic [PC_W-1:0] new_pc;
  logic [15:0]     instruction;
  logic            zero_flag = 1'b0;
  logic            exec_busy = 1'b0;
  logic            op_valid;
  logic            op_ready = 1'b0;
  logic [3:0]      op_code;
  logic [3:0]      op_rd;
  logic [3:0]      op_rs;
  logic [3:0]      op_rt;
  logic [PC_W-1:0] op_pc;
  logic            halted;

  fetch_sequencer #(.PC_W(PC_W)) dut (
    .clk(clk),
    .reset(reset),
    .en_pc(en_pc),
    .en_new_pc(en_new_pc),
    .new_pc(new_pc),
    .instruction(instruction),
    .zero_flag(zero_flag),
    .exec_busy(exec_busy),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_code(op_code),
    .op_rd(op_rd),
    .op_rs(op_rs),
    .op_rt(op_rt),
    .op_pc(op_pc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0]     mem [4096];
  logic [PC_W-1:0] fpc;

  // fetch unit model: redirect wins over sequential fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc         <= '0;
      instruction <= '0;
    end else if (en_new_pc) begin
      instruction <= mem[new_pc];
      fpc         <= new_pc;
    end else if (en_pc) begin
      instruction <= mem[fpc];
      fpc         <= fpc + 12'd1;
    end
  end

  typedef logic [27:0] op_t;
  op_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor samples just before the edge where the handshake completes
  always begin
    @(negedge clk);
    #4;
    if (!reset && op_valid && op_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_op: got %0h want none",
                 {op_code, op_rd, op_rs, op_rt, op_pc});
      end else begin
        check("op_fields", {op_code, op_rd, op_rs, op_rt, op_pc},
              sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_on();
    reset     = 1'b1;
    op_ready  = 1'b0;
    exec_busy = 1'b0;
    zero_flag = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic reset_off();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [5:0] pat;
  logic [1:0] vv;
  int         bad;
  logic       seen_np;

  initial begin
    // reset, NOP then ALU op
    reset_on();
    mem[1] = 16'h1123;
    sb.push_back({4'h1, 4'h1, 4'h2, 4'h3, 12'h001});
    op_ready = 1'b1;
    reset_off();
    check("reset_vals", {en_pc, en_new_pc, new_pc, op_valid, op_code,
          op_rd, op_rs, op_rt, op_pc, halted}, 64'd0);
    pat = '0;
    vv  = '0;
    for (int t = 0; t < 6; t++) begin
      if (t > 0) tick();
      pat[t] = en_pc;
      if (t == 4) vv[1] = op_valid;
      if (t == 5) vv[0] = op_valid;
    end
    check("nop_alu_en_pc", 64'(pat), 64'(6'b001010));
    check("alu_latency", 64'(vv), 64'(2'b01));
    repeat (3) tick();

    // backpressure for four cycles
    reset_on();
    mem[0] = 16'h5ABC;
    sb.push_back({4'h5, 4'hA, 4'hB, 4'hC, 12'h000});
    reset_off();
    bad = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t >= 3 && t <= 7) begin
        if (!op_valid || en_pc ||
            {op_code, op_rd, op_rs, op_rt, op_pc} !== 28'h5ABC000)
          bad++;
      end
      if (t == 7) op_ready = 1'b1;
      if (t == 8) check("bp_en_pc_after", 64'(en_pc), 64'd1);
    end
    check("bp_hold_bad_cycles", 64'(bad), 64'd0);
    repeat (2) tick();

    // JMP 0x100
    reset_on();
    mem[0]     = 16'hA100;
    mem[12'h100] = 16'h2456;
    sb.push_back({4'h2, 4'h4, 4'h5, 4'h6, 12'h100});
    op_ready = 1'b1;
    reset_off();
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 3) check("jmp_redirect", {en_new_pc, en_pc, new_pc},
                        {1'b1, 1'b0, 12'h100});
      if (t == 4) check("jmp_target_fetch", {en_new_pc, en_pc}, 2'b01);
    end
    repeat (2) tick();

    // JZ taken after three busy cycles
    reset_on();
    mem[0]       = 16'hB020;
    mem[12'h020] = 16'h3111;
    sb.push_back({4'h3, 4'h1, 4'h1, 4'h1, 12'h020});
    op_ready = 1'b1;
    reset_off();
    exec_busy = 1'b1;
    zero_flag = 1'b0;
    bad = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t >= 3 && t <= 5 && (en_pc || en_new_pc)) bad++;
      if (t == 5) begin
        exec_busy = 1'b0;
        zero_flag = 1'b1;
      end
      if (t == 6) check("jz_taken", {en_new_pc, en_pc, new_pc},
                        {1'b1, 1'b0, 12'h020});
      if (t == 7) check("jz_target_fetch", 64'(en_pc), 64'd1);
    end
    check("jz_stall_quiet", 64'(bad), 64'd0);
    repeat (2) tick();

    // JZ not taken after three busy cycles
    reset_on();
    mem[0] = 16'hB020;
    mem[1] = 16'h4321;
    sb.push_back({4'h4, 4'h3, 4'h2, 4'h1, 12'h001});
    op_ready = 1'b1;
    reset_off();
    exec_busy = 1'b1;
    zero_flag = 1'b1;
    seen_np = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      seen_np = seen_np | en_new_pc;
      if (t == 5) begin
        exec_busy = 1'b0;
        zero_flag = 1'b0;
      end
      if (t == 6) check("jz_not_taken_fetch", 64'(en_pc), 64'd1);
    end
    check("jz_no_redirect", 64'(seen_np), 64'd0);
    repeat (2) tick();

    // wrap from 0xFFF to 0x000, then HALT
    reset_on();
    mem[0]       = 16'hAFFF;
    mem[12'hFFF] = 16'h3000;
    sb.push_back({4'h3, 4'h0, 4'h0, 4'h0, 12'hFFF});
    op_ready = 1'b1;
    reset_off();
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t == 2) mem[0] = 16'hF000;
      if (t == 3) check("wrap_redirect", {en_new_pc, new_pc},
                        {1'b1, 12'hFFF});
      if (t == 8) check("halted_not_yet", 64'(halted), 64'd0);
      if (t == 9) check("halted_set", 64'(halted), 64'd1);
    end
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (en_pc || en_new_pc || op_valid || !halted) bad++;
    end
    check("halt_quiet_20", 64'(bad), 64'd0);

    // reset while an op is waiting
    reset_on();
    mem[0] = 16'h7123;
    reset_off();
    repeat (4) tick();
    check("pre_reset_valid", 64'(op_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("async_clear", {op_valid, halted, en_pc, en_new_pc}, 4'b0000);
    sb.push_back({4'h7, 4'h1, 4'h2, 4'h3, 12'h000});
    op_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 1) check("restart_en_pc", 64'(en_pc), 64'd1);
    end
    repeat (2) tick();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
